// File: rtl/hazard_pkg.sv
// Shared types and constants for the rv32 hazard unit: scoreboard entry layout
// and the reserved encodings for "no forwarding" and the zero register.
package hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  localparam int         FWD_RF   = 0;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Resolves one decode source operand against the scoreboard: picks the youngest
// in-flight producer, forwarding its stage result or flagging a hazard if not ready.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int NSTAGE     = 3,
  parameter  int LOAD_STAGE = 1,
  localparam int FWD_W      = $clog2(NSTAGE + 1)
) (
  input  logic [4:0]             rs_i,
  input  logic                   use_i,
  input  logic [XLEN-1:0]        rf_data_i,
  input  logic [NSTAGE*XLEN-1:0] stage_data_i,
  input  logic [NSTAGE-1:0]      sb_valid_i,
  input  logic [NSTAGE*5-1:0]    sb_rd_i,
  input  logic [NSTAGE-1:0]      sb_load_i,
  output logic [XLEN-1:0]        data_o,
  output logic [FWD_W-1:0]       fwd_o,
  output logic                   hazard_o
);

  logic [NSTAGE-1:0] match;

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_match
      assign match[gi] = use_i && (rs_i != REG_ZERO) && sb_valid_i[gi]
                         && (sb_rd_i[gi*5 +: 5] == rs_i);
    end
  endgenerate

  // Walk oldest to youngest so the youngest matching stage wins.
  always_comb begin
    data_o   = rf_data_i;
    fwd_o    = FWD_W'(FWD_RF);
    hazard_o = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (match[k]) begin
        if (sb_load_i[k] && (k < LOAD_STAGE)) begin
          hazard_o = 1'b1;
          fwd_o    = FWD_W'(FWD_RF);
          data_o   = rf_data_i;
        end else begin
          hazard_o = 1'b0;
          fwd_o    = FWD_W'(k + 1);
          data_o   = stage_data_i[k*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Data/control hazard unit: in-flight destination scoreboard, operand forwarding,
// load-use stall, multi-cycle redirect flush and saturating debug event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int NSTAGE     = 3,
  parameter  int LOAD_STAGE = 1,
  parameter  int FLUSH_N    = 2,
  parameter  int CNT_W      = 16,
  localparam int FWD_W      = $clog2(NSTAGE + 1)
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   de_valid_i,
  input  logic [4:0]             de_rs1_i,
  input  logic [4:0]             de_rs2_i,
  input  logic                   de_use_rs1_i,
  input  logic                   de_use_rs2_i,
  input  logic [4:0]             de_rd_i,
  input  logic                   de_wen_i,
  input  logic                   de_is_load_i,
  input  logic [XLEN-1:0]        rf_data_a_i,
  input  logic [XLEN-1:0]        rf_data_b_i,
  input  logic [NSTAGE*XLEN-1:0] stage_data_i,
  input  logic                   redirect_i,
  output logic [XLEN-1:0]        data_a_o,
  output logic [XLEN-1:0]        data_b_o,
  output logic [FWD_W-1:0]       fwd_a_o,
  output logic [FWD_W-1:0]       fwd_b_o,
  output logic                   stall_o,
  output logic                   flush_o,
  output logic [CNT_W-1:0]       stall_count_o,
  output logic [CNT_W-1:0]       flush_count_o
);

  localparam int FC_W = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;

  sb_entry_t         sb_q [NSTAGE];
  sb_entry_t         sb_new;
  logic [NSTAGE-1:0] sb_valid;
  logic [NSTAGE*5-1:0] sb_rd;
  logic [NSTAGE-1:0] sb_load;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;
  logic              hazard_a, hazard_b;

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_sb_flat
      assign sb_valid[gi]        = sb_q[gi].valid;
      assign sb_rd[gi*5 +: 5]    = sb_q[gi].rd;
      assign sb_load[gi]         = sb_q[gi].is_load;
    end
  endgenerate

  hazard_fwd_sel #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE)) u_sel_a (
    .rs_i(de_rs1_i), .use_i(de_use_rs1_i), .rf_data_i(rf_data_a_i),
    .stage_data_i(stage_data_i), .sb_valid_i(sb_valid), .sb_rd_i(sb_rd),
    .sb_load_i(sb_load), .data_o(data_a_o), .fwd_o(fwd_a_o), .hazard_o(hazard_a)
  );

  hazard_fwd_sel #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE)) u_sel_b (
    .rs_i(de_rs2_i), .use_i(de_use_rs2_i), .rf_data_i(rf_data_b_i),
    .stage_data_i(stage_data_i), .sb_valid_i(sb_valid), .sb_rd_i(sb_rd),
    .sb_load_i(sb_load), .data_o(data_b_o), .fwd_o(fwd_b_o), .hazard_o(hazard_b)
  );

  assign flush_o = redirect_i || (flush_cnt_q != '0);
  assign stall_o = de_valid_i && (hazard_a || hazard_b) && !flush_o;

  // Stalled or flushed decode slots enter EXE as bubbles.
  always_comb begin
    sb_new.valid   = de_valid_i && de_wen_i && (de_rd_i != REG_ZERO) && !stall_o && !flush_o;
    sb_new.rd      = de_rd_i;
    sb_new.is_load = de_is_load_i;

    if (redirect_i)               flush_cnt_d = FC_W'(FLUSH_N - 1);
    else if (flush_cnt_q != '0)   flush_cnt_d = flush_cnt_q - 1'b1;
    else                          flush_cnt_d = flush_cnt_q;

    stall_count_d = stall_count_q;
    if (stall_o && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;

    flush_count_d = flush_count_q;
    if (redirect_i && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int k = 0; k < NSTAGE; k++) sb_q[k] <= '0;
      flush_cnt_q   <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      sb_q[0] <= sb_new;
      for (int k = 1; k < NSTAGE; k++) sb_q[k] <= sb_q[k-1];
      flush_cnt_q   <= flush_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count_o = stall_count_q;
  assign flush_count_o = flush_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized plus directed bench for hazard_unit against a queue-based model of
// the in-flight instruction window and a cycle-window model of redirect flushes.
module tb_hazard_unit;

  localparam int XLEN       = 32;
  localparam int NSTAGE     = 3;
  localparam int LOAD_STAGE = 1;
  localparam int FLUSH_N    = 2;
  localparam int CNT_W      = 10;
  localparam int FWD_W      = $clog2(NSTAGE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                   clk = 1'b0;
  logic                   srst;
  logic                   de_valid, de_use_rs1, de_use_rs2, de_wen, de_is_load, redirect;
  logic [4:0]             de_rs1, de_rs2, de_rd;
  logic [XLEN-1:0]        rf_data_a, rf_data_b, data_a, data_b;
  logic [NSTAGE*XLEN-1:0] stage_data;
  logic [FWD_W-1:0]       fwd_a, fwd_b;
  logic                   stall, flush;
  logic [CNT_W-1:0]       stall_count, flush_count;

  always #5 clk = ~clk;

  hazard_unit #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE),
                .FLUSH_N(FLUSH_N), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .srst_i(srst), .de_valid_i(de_valid),
    .de_rs1_i(de_rs1), .de_rs2_i(de_rs2), .de_use_rs1_i(de_use_rs1), .de_use_rs2_i(de_use_rs2),
    .de_rd_i(de_rd), .de_wen_i(de_wen), .de_is_load_i(de_is_load),
    .rf_data_a_i(rf_data_a), .rf_data_b_i(rf_data_b), .stage_data_i(stage_data),
    .redirect_i(redirect), .data_a_o(data_a), .data_b_o(data_b),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall), .flush_o(flush),
    .stall_count_o(stall_count), .flush_count_o(flush_count)
  );

  // Model: window of the last NSTAGE decode slots, youngest at index 0.
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } inst_t;

  inst_t   window[$];
  longint  cyc;
  longint  flush_end;
  int      m_stall_cnt, m_flush_cnt;
  int      n_vec, n_err;
  bit      rand_data;
  bit      verbose;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    window.delete();
    for (int i = 0; i < NSTAGE; i++) window.push_back('{v: 1'b0, rd: 0, ld: 1'b0});
    flush_end   = cyc;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic resolve(input int rs, input bit use_, output int fwd, output bit haz);
    bit found;
    fwd   = 0;
    haz   = 1'b0;
    found = 1'b0;
    if (use_ && rs != 0) begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (!found && window[k].v && window[k].rd == rs) begin
          found = 1'b1;
          if (window[k].ld && k < LOAD_STAGE) haz = 1'b1;
          else fwd = k + 1;
        end
      end
    end
  endtask

  task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit wen, input bit ld, input bit redir, input bit rst_in);
    int fa, fb;
    bit ha, hb, e_flush, e_stall;
    logic [XLEN-1:0] e_da, e_db;
    @(negedge clk);
    srst = rst_in; de_valid = v; de_rs1 = 5'(rs1); de_use_rs1 = u1; de_rs2 = 5'(rs2);
    de_use_rs2 = u2; de_rd = 5'(rd); de_wen = wen; de_is_load = ld; redirect = redir;
    rf_data_a = $urandom; rf_data_b = $urandom;
    if (rand_data) stage_data = {$urandom, $urandom, $urandom};
    #1;
    resolve(rs1, u1, fa, ha);
    resolve(rs2, u2, fb, hb);
    e_da    = (fa == 0) ? rf_data_a : stage_data[(fa-1)*XLEN +: XLEN];
    e_db    = (fb == 0) ? rf_data_b : stage_data[(fb-1)*XLEN +: XLEN];
    e_flush = redir || (cyc < flush_end);
    e_stall = v && (ha || hb) && !e_flush;
    chk_eq("fwd_a", 64'(fwd_a), 64'(fa));
    chk_eq("fwd_b", 64'(fwd_b), 64'(fb));
    chk_eq("data_a", 64'(data_a), 64'(e_da));
    chk_eq("data_b", 64'(data_b), 64'(e_db));
    chk_eq("flush", 64'(flush), 64'(e_flush));
    chk_eq("stall", 64'(stall), 64'(e_stall));
    chk_eq("stall_count", 64'(stall_count), 64'(m_stall_cnt));
    chk_eq("flush_count", 64'(flush_count), 64'(m_flush_cnt));
    if (verbose)
      $display("cyc %0d rst=%0b v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d wen=%0b ld=%0b redir=%0b -> fwd_a=%0d fwd_b=%0d stall=%0b flush=%0b sc=%0d fc=%0d",
               cyc, rst_in, v, rs1, u1, rs2, u2, rd, wen, ld, redir, fwd_a, fwd_b, stall, flush,
               stall_count, flush_count);
    if (rst_in) begin
      cyc++;
      model_clear();
    end else begin
      window.push_front('{v: (v && wen && rd != 0 && !e_stall && !e_flush), rd: rd, ld: ld});
      void'(window.pop_back());
      if (redir) flush_end = cyc + FLUSH_N;
      if (e_stall && m_stall_cnt < int'(CNT_MAX)) m_stall_cnt++;
      if (redir && m_flush_cnt < int'(CNT_MAX)) m_flush_cnt++;
      cyc++;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; rand_data = 1'b1; verbose = 1'b1;
    srst = 1'b1; de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0;
    de_rd = 0; de_wen = 0; de_is_load = 0; redirect = 0; rf_data_a = 0; rf_data_b = 0;
    stage_data = '0;
    model_clear();
    do_reset();
    // Reset state: passthrough from RF, no stall/flush, counters zero.
    step(1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
    chk_eq("rst_fwd_a", 64'(fwd_a), 64'd0);
    chk_eq("rst_data_a", 64'(data_a), 64'(rf_data_a));
    chk_eq("rst_stall_count", 64'(stall_count), 64'd0);

    // ALU back-to-back.
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    rand_data = 1'b0; stage_data = {32'h0, 32'h0, 32'h1234};
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("alu_fwd_a", 64'(fwd_a), 64'd1);
    chk_eq("alu_data_a", 64'(data_a), 64'h1234);
    chk_eq("alu_stall", 64'(stall), 64'd0);
    rand_data = 1'b1;

    // Load-use: one stall, then forward from stage 1.
    do_reset();
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(1, 0, 0, 7, 1, 9, 1, 0, 0, 0);
    chk_eq("lu_stall", 64'(stall), 64'd1);
    step(1, 0, 0, 7, 1, 9, 1, 0, 0, 0);
    chk_eq("lu_fwd_b", 64'(fwd_b), 64'd2);
    chk_eq("lu_data_b", 64'(data_b), 64'(stage_data[XLEN +: XLEN]));
    chk_eq("lu_stall2", 64'(stall), 64'd0);
    chk_eq("lu_stall_count", 64'(stall_count), 64'd1);

    // x0 never tracked; unused operand reads RF.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 9, 0, 0, 0, 0, 0, 0);
    chk_eq("x0_fwd_a", 64'(fwd_a), 64'd0);
    chk_eq("unused_fwd_b", 64'(fwd_b), 64'd0);
    chk_eq("unused_data_b", 64'(data_b), 64'(rf_data_b));

    // Priority: youngest of two writes to x3.
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    rand_data = 1'b0; stage_data = {32'h0, 32'hA, 32'hB};
    step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("prio_fwd_a", 64'(fwd_a), 64'd1);
    chk_eq("prio_data_a", 64'(data_a), 64'hB);
    rand_data = 1'b1;

    // Redirect concurrent with a load-use hazard.
    do_reset();
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(1, 0, 0, 7, 1, 8, 1, 0, 1, 0);
    chk_eq("rd_flush0", 64'(flush), 64'd1);
    chk_eq("rd_stall0", 64'(stall), 64'd0);
    step(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
    chk_eq("rd_flush1", 64'(flush), 64'd1);
    step(1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
    chk_eq("rd_flush2", 64'(flush), 64'd0);
    chk_eq("rd_fwd_b_bubble", 64'(fwd_b), 64'd0);
    chk_eq("rd_flush_count", 64'(flush_count), 64'd1);

    // Reset mid-flush.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset();
    idle();
    chk_eq("rmf_flush", 64'(flush), 64'd0);
    chk_eq("rmf_flush_count", 64'(flush_count), 64'd0);

    // Random traffic with occasional reset.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 99) == 0);
    end

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 2 * (int'(CNT_MAX) + 8); i++) step(1, 7, 1, 0, 0, 7, 1, 1, 0, 0);
    idle();
    chk_eq("stall_sat", 64'(stall_count), 64'(CNT_MAX));
    for (int i = 0; i < int'(CNT_MAX) + 8; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    chk_eq("flush_sat", 64'(flush_count), 64'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
